// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, captures same-cycle RAM data into a prefetch queue, one-cycle head latency.
// Decode backpressure fills the queue, then fetch stalls with the PC held; redirect flushes all but a head popped that cycle.
module fetch_unit #(
  parameter int          PC_W     = 8,
  parameter int          INSTR_W  = 32,
  parameter int          QDEPTH   = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_en,
  output logic [PC_W-1:0]            pc_addr,
  input  logic [INSTR_W-1:0]         fetch_instr_in,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       instr_valid,
  output logic [INSTR_W-1:0]         instr_out,
  output logic [PC_W-1:0]            instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(QDEPTH):0]    q_count
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [INSTR_W-1:0] instr_mem_q [QDEPTH];
  logic [PC_W-1:0]    pc_mem_q    [QDEPTH];

  logic head_vld;
  logic pop;
  logic push;
  logic not_full;

  assign head_vld = (cnt_q != '0);
  assign not_full = (cnt_q < CNT_W'(QDEPTH));
  assign pop      = head_vld & instr_ready;
  // A full queue can still accept a fetch when the head leaves in the same cycle.
  assign push     = fetch_en & ~redirect_valid & (not_full | pop);

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (redirect_valid) begin
      // Flush: the head popped this cycle is already consumed by decode.
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= PC_W'(RESET_PC);
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= fetch_instr_in;
      pc_mem_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign pc_addr     = pc_q;
  assign q_count     = cnt_q;
  assign instr_valid = head_vld;
  assign instr_out   = head_vld ? instr_mem_q[rd_ptr_q] : '0;
  assign instr_pc    = head_vld ? pc_mem_q[rd_ptr_q]    : '0;

endmodule
